// File: rtl/rom_stream_reader.sv
// rom_stream_reader
//
// Burst sequencer placed in front of a block ROM that has a one-cycle registered read. A single
// start request (startAddr, length) becomes a stream of ROM words on a valid/ready interface.
// A two-entry FIFO absorbs the ROM latency. A read is issued only when the FIFO is sure to have
// room for its word, so the consumer may stall on any cycle without loss or duplication.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high; aborts any burst and discards buffered words
//   start        burst request, honoured only while busy is low
//   startAddr    address of the first word (must be < memDepth)
//   length       number of words in the burst; 0 completes immediately
//   romAddress   ROM read address
//   romEnable    ROM read enable; high only on cycles that issue a read
//   romData      ROM read data, valid the cycle after romEnable
//   dataOut      stream word (FIFO head)
//   dataValid    dataOut holds a valid word
//   dataReady    consumer accepts; a handshake is dataValid & dataReady at a rising edge
//   dataLast     high together with the final word of the burst
//   busy         burst in progress
//   done         one-cycle pulse after the final handshake of a burst

module rom_stream_reader #(
  parameter int unsigned blockLength = 12,
  parameter int unsigned memDepth    = 250,
  localparam int unsigned addressBitWidth = (memDepth > 1) ? $clog2(memDepth) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [addressBitWidth-1:0] startAddr,
  input  logic [addressBitWidth:0]   length,
  output logic [addressBitWidth-1:0] romAddress,
  output logic                       romEnable,
  input  logic [blockLength-1:0]     romData,
  output logic [blockLength-1:0]     dataOut,
  output logic                       dataValid,
  input  logic                       dataReady,
  output logic                       dataLast,
  output logic                       busy,
  output logic                       done
);

  localparam logic [addressBitWidth-1:0] AddrLast = addressBitWidth'(memDepth - 1);
  localparam logic [addressBitWidth-1:0] AddrOne  = addressBitWidth'(1);
  localparam logic [addressBitWidth:0]   CntOne   = (addressBitWidth + 1)'(1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

  // Sequencer state
  state_e                     state_q;
  logic [addressBitWidth-1:0] addr_q;       // next ROM address to read
  logic [addressBitWidth:0]   remaining_q;  // reads still to issue
  logic [addressBitWidth:0]   length_q;     // burst length, kept for dataLast / completion
  logic [addressBitWidth:0]   hs_count_q;   // handshakes completed in this burst
  logic                       busy_q;
  logic                       done_q;

  // Read pipeline and buffering
  logic                       in_flight_q;  // a read was issued last cycle; romData is real
  logic [1:0]                 fifo_count_q;
  logic                       fifo_rd_ptr_q;
  logic                       fifo_wr_ptr_q;
  logic [blockLength-1:0]     fifo_mem_q [2];

  // Combinational control
  logic                       pop;
  logic                       issue;
  logic                       credit_ok;
  logic [1:0]                 occupancy;
  logic [addressBitWidth-1:0] addr_next;
  logic [addressBitWidth:0]   hs_count_next;
  logic                       drain_done;

  always_comb begin
    dataValid = (fifo_count_q != 2'd0);
    pop       = dataValid & dataReady;

    // Words already committed to the buffer: stored plus the one arriving from the ROM.
    // Credit = 2 - occupancy + pop; a read may go out while that is positive. A pop in the
    // same cycle frees a slot in time for the word that lands two edges later.
    occupancy = fifo_count_q + {1'b0, in_flight_q};
    credit_ok = (occupancy < 2'd2) || (pop && (occupancy == 2'd2));

    issue = (state_q == StIssue) && (remaining_q != '0) && credit_ok;

    addr_next = (addr_q == AddrLast) ? '0 : addr_q + AddrOne;

    // Completion looks at the post-edge values so done rises right after the last handshake.
    hs_count_next = hs_count_q + {{addressBitWidth{1'b0}}, pop};
    drain_done    = (state_q == StDrain) && !in_flight_q &&
                    (fifo_count_q == {1'b0, pop}) && (hs_count_next == length_q);
  end

  // romEnable depends on this cycle's pop, so it cannot be registered without losing
  // back-to-back throughput; it is decoded from registered state plus dataReady.
  assign romEnable  = issue;
  assign romAddress = addr_q;
  assign dataOut    = fifo_mem_q[fifo_rd_ptr_q];
  assign dataLast   = dataValid && (hs_count_q == length_q - CntOne);
  assign busy       = busy_q;
  assign done       = done_q;

  // Sequencer FSM with its counters and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      length_q    <= '0;
      hs_count_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) begin
        hs_count_q <= hs_count_next;
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            addr_q      <= startAddr;
            remaining_q <= length;
            length_q    <= length;
            hs_count_q  <= '0;
            busy_q      <= 1'b1;
            state_q     <= (length == '0) ? StDrain : StIssue;
          end
        end

        StIssue: begin
          if (issue) begin
            addr_q      <= addr_next;
            remaining_q <= remaining_q - CntOne;
            if (remaining_q == CntOne) begin
              state_q <= StDrain;
            end
          end
        end

        StDrain: begin
          if (drain_done) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // Read pipeline and two-entry FIFO. A write and a pop may coincide; when full the write
  // lands in the slot being popped, which becomes the new tail.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_flight_q   <= 1'b0;
      fifo_count_q  <= 2'd0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
    end else begin
      in_flight_q <= issue;

      // The ROM drives 0 when not enabled, so only trust romData behind an issued read.
      if (in_flight_q) begin
        fifo_mem_q[fifo_wr_ptr_q] <= romData;
        fifo_wr_ptr_q             <= ~fifo_wr_ptr_q;
      end

      if (pop) begin
        fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      end

      fifo_count_q <= fifo_count_q + {1'b0, in_flight_q} - {1'b0, pop};
    end
  end

endmodule
